// File: rtl/icb_pkg.sv
// ----------------------------------------------------------------------------
// icb_pkg
// Shared types and constants for the ICB stream master slice.
//   state_t        : controller state (IDLE/RUN/DRAIN/FINISH)
//   icb_cmd_t      : one ICB command beat (read, addr, wdata, wmask)
//   ICB_DW/ICB_AW  : ICB data/address widths
//   ICB_WMASK_FULL : full-word byte mask
//   WORD_BYTES     : address stride between consecutive words
// ----------------------------------------------------------------------------
package icb_pkg;

    localparam int ICB_DW     = 32;
    localparam int ICB_AW     = 32;
    localparam int WORD_BYTES = 4;
    localparam logic [3:0] ICB_WMASK_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    typedef struct packed {
        logic              read;
        logic [ICB_AW-1:0] addr;
        logic [ICB_DW-1:0] wdata;
        logic [3:0]        wmask;
    } icb_cmd_t;

    // Address of word idx in a contiguous range; wraps modulo 2^ICB_AW.
    function automatic logic [ICB_AW-1:0] word_addr(input logic [ICB_AW-1:0] base,
                                                    input logic [ICB_AW-1:0] idx);
        return base + idx * ICB_AW'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/icb_stream_master_if.sv
// ----------------------------------------------------------------------------
// icb_stream_master_if
// ICB command/response channel bundle.
//   master modport : drives cmd_valid/read/addr/wdata/wmask and rsp_ready
//   slave  modport : drives cmd_ready and rsp_valid/rdata/err
// ----------------------------------------------------------------------------
interface icb_stream_master_if;
    import icb_pkg::*;

    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic              icb_cmd_read;
    logic [ICB_AW-1:0] icb_cmd_addr;
    logic [ICB_DW-1:0] icb_cmd_wdata;
    logic [3:0]        icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic [ICB_DW-1:0] icb_rsp_rdata;
    logic              icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

endinterface

// File: rtl/icb_ostd_cnt.sv
// ----------------------------------------------------------------------------
// icb_ostd_cnt
// Outstanding-transaction up/down counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (new transfer)
//   inc        : a command was accepted
//   dec        : a response was accepted
//   count      : commands issued but not yet responded
//   full       : count == MAX_OSTD
// ----------------------------------------------------------------------------
module icb_ostd_cnt #(
    parameter int MAX_OSTD = 4,
    parameter int CNT_W    = $clog2(MAX_OSTD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    assign full = (count == CNT_W'(MAX_OSTD));

    // Saturating at both ends: the issue logic already stops at full, the
    // guards only keep the counter sane against a misbehaving slave.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   if (!full)        count <= count + CNT_W'(1);
                2'b01:   if (count != '0)  count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/icb_stream_master.sv
// ----------------------------------------------------------------------------
// icb_stream_master
// ICB initiator moving cfg_len 32-bit words between a valid/ready stream and
// a contiguous ICB address range, with up to MAX_OSTD outstanding commands.
//   clk, rst_n          : clock, synchronous active-low reset
//   cfg_start/read/base/len : transfer request (taken only in IDLE)
//   busy, done, err     : status (done is a 1-cycle pulse, err is sticky)
//   s_valid/s_ready/s_data : stream-in, write mode
//   m_valid/m_ready/m_data : stream-out, read mode (unbuffered from ICB rsp)
//   icb                 : ICB master port
// ----------------------------------------------------------------------------
module icb_stream_master
    import icb_pkg::*;
#(
    parameter int MAX_OSTD = 4,
    parameter int LEN_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_read,
    input  logic [ICB_AW-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ICB_DW-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ICB_DW-1:0] m_data,
    icb_stream_master_if.master icb
);

    localparam int OSTD_W = $clog2(MAX_OSTD + 1);

    state_t            state_q, state_d;
    logic [ICB_AW-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic              dir_q;
    logic [LEN_W-1:0]  cmd_cnt_q, rsp_cnt_q;
    logic [LEN_W-1:0]  cmd_cnt_nxt, rsp_cnt_nxt;
    logic              err_q;

    logic              active;
    logic              start_acc;
    logic              issue;
    logic              cmd_valid;
    logic              rsp_ready;
    logic              cmd_hs, rsp_hs;
    logic [OSTD_W-1:0] ostd_cnt;
    logic              ostd_full;
    icb_cmd_t          cmd;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign start_acc = (state_q == IDLE) && cfg_start;
    assign issue     = (state_q == RUN) && (cmd_cnt_q < len_q) && !ostd_full;

    // Write mode needs a stream word in hand before a command can go out.
    assign cmd_valid = issue && (dir_q || s_valid);
    assign cmd_hs    = cmd_valid && icb.icb_cmd_ready;

    // Outside a transfer every response is swallowed so stale traffic from an
    // abandoned transfer cannot wedge the bus. In read mode the response is
    // passed straight through, so backpressure comes from the stream sink.
    assign rsp_ready = (active && dir_q) ? m_ready : 1'b1;
    assign rsp_hs    = active && icb.icb_rsp_valid && rsp_ready;

    assign cmd_cnt_nxt = cmd_cnt_q + LEN_W'(cmd_hs);
    assign rsp_cnt_nxt = rsp_cnt_q + LEN_W'(rsp_hs);

    // Command fields derive only from registered state and s_data, which the
    // stream source holds while s_valid waits for s_ready.
    always_comb begin
        cmd       = '0;
        cmd.read  = dir_q;
        cmd.addr  = word_addr(base_q, ICB_AW'(cmd_cnt_q));
        cmd.wdata = s_data;
        cmd.wmask = ICB_WMASK_FULL;
    end

    assign icb.icb_cmd_valid = cmd_valid;
    assign icb.icb_cmd_read  = cmd.read;
    assign icb.icb_cmd_addr  = cmd.addr;
    assign icb.icb_cmd_wdata = cmd.wdata;
    assign icb.icb_cmd_wmask = cmd.wmask;
    assign icb.icb_rsp_ready = rsp_ready;

    assign s_ready = issue && !dir_q && icb.icb_cmd_ready;
    assign m_valid = active && dir_q && icb.icb_rsp_valid;
    assign m_data  = icb.icb_rsp_rdata;

    assign busy = active;
    assign done = (state_q == FINISH);
    assign err  = err_q;

    // ------------------------------------------------------------------
    // Outstanding counter
    // ------------------------------------------------------------------
    icb_ostd_cnt #(
        .MAX_OSTD (MAX_OSTD),
        .CNT_W    (OSTD_W)
    ) u_ostd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .inc   (cmd_hs),
        .dec   (rsp_hs),
        .count (ostd_cnt),
        .full  (ostd_full)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) state_d = (cfg_len != '0) ? RUN : FINISH;
            end
            RUN: begin
                // A zero-latency slave can answer the last command in the
                // same cycle it is taken, so DRAIN may be skipped entirely.
                if (cmd_cnt_nxt == len_q)
                    state_d = (rsp_cnt_nxt == len_q) ? FINISH : DRAIN;
            end
            DRAIN: begin
                // No commands issue here, so the response that drains the
                // last outstanding slot is also the final one.
                if (rsp_hs && (ostd_cnt == OSTD_W'(1)) && (rsp_cnt_nxt == len_q))
                    state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer context and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            dir_q     <= 1'b0;
            cmd_cnt_q <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (start_acc) begin
            base_q    <= cfg_base & ~ICB_AW'(3);
            len_q     <= cfg_len;
            dir_q     <= cfg_read;
            cmd_cnt_q <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
        end else if (active) begin
            cmd_cnt_q <= cmd_cnt_nxt;
            rsp_cnt_q <= rsp_cnt_nxt;
            if (rsp_hs && icb.icb_rsp_err) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icb_stream_master.sv
// ----------------------------------------------------------------------------
// tb_icb_stream_master
// Directed bench: the bench plays the ICB slave and both stream ends, one
// cycle at a time, and compares outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_icb_stream_master;
    import icb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, cfg_read;
    logic [31:0] cfg_base;
    logic [15:0] cfg_len;
    logic        busy, done, err;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_ready;
    logic [31:0] m_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icb_stream_master_if bus ();

    icb_stream_master #(
        .MAX_OSTD (4),
        .LEN_W    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_read  (cfg_read),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .icb       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the active edge; outputs are
    // sampled another unit later, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        cfg_start              = 1'b0;
        s_valid                = 1'b0;
        s_data                 = '0;
        m_ready                = 1'b1;
        bus.icb_cmd_ready      = 1'b1;
        bus.icb_rsp_valid      = 1'b0;
        bus.icb_rsp_rdata      = '0;
        bus.icb_rsp_err        = 1'b0;
    endtask

    logic [31:0] a;

    initial begin
        rst_n    = 1'b0;
        cfg_read = 1'b0;
        cfg_base = '0;
        cfg_len  = '0;
        idle_inputs();

        // ---------------- reset state ----------------
        tick(); tick();
        settle();
        chk("rst busy",      32'(busy), 0);
        chk("rst done",      32'(done), 0);
        chk("rst err",       32'(err), 0);
        chk("rst cmd_valid", 32'(bus.icb_cmd_valid), 0);
        chk("rst s_ready",   32'(s_ready), 0);
        chk("rst m_valid",   32'(m_valid), 0);
        chk("rst rsp_ready", 32'(bus.icb_rsp_ready), 1);
        rst_n = 1'b1;
        tick();

        // ---------------- T1: write, len=4 ----------------
        cfg_start = 1'b1; cfg_read = 1'b0; cfg_base = 32'h1000_0000; cfg_len = 16'd4;
        settle();
        chk("t1 busy pre", 32'(busy), 0);
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid           = (i < 4);
            s_data            = 32'hA000_0000 + 32'(i);
            bus.icb_rsp_valid = (i >= 1);
            settle();
            chk("t1 busy", 32'(busy), 1);
            chk("t1 done early", 32'(done), 0);
            if (i < 4) begin
                chk("t1 cmd_valid", 32'(bus.icb_cmd_valid), 1);
                chk("t1 addr",      bus.icb_cmd_addr, 32'h1000_0000 + 32'(4 * i));
                chk("t1 wdata",     bus.icb_cmd_wdata, 32'hA000_0000 + 32'(i));
                chk("t1 wmask",     32'(bus.icb_cmd_wmask), 32'hF);
                chk("t1 cmd_read",  32'(bus.icb_cmd_read), 0);
                chk("t1 s_ready",   32'(s_ready), 1);
            end else begin
                chk("t1 drain cmd_valid", 32'(bus.icb_cmd_valid), 0);
                chk("t1 drain s_ready",   32'(s_ready), 0);
            end
            tick();
        end
        idle_inputs();
        settle();
        chk("t1 done",  32'(done), 1);
        chk("t1 busy0", 32'(busy), 0);
        chk("t1 err",   32'(err), 0);
        tick();
        chk("t1 done once", 32'(done), 0);

        // ---------------- T2: read, len=3, sink stalls ----------------
        cfg_start = 1'b1; cfg_read = 1'b1; cfg_base = 32'h2000_0000; cfg_len = 16'd3;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2 cmd_valid", 32'(bus.icb_cmd_valid), 1);
            chk("t2 cmd_read",  32'(bus.icb_cmd_read), 1);
            chk("t2 addr",      bus.icb_cmd_addr, 32'h2000_0000 + 32'(4 * i));
            chk("t2 m_valid0",  32'(m_valid), 0);
            tick();
        end
        bus.icb_rsp_valid = 1'b1; bus.icb_rsp_rdata = 32'hB000_0000; m_ready = 1'b1;
        settle();
        chk("t2 drain cmd_valid", 32'(bus.icb_cmd_valid), 0);
        chk("t2 m_valid r0",      32'(m_valid), 1);
        chk("t2 m_data r0",       m_data, 32'hB000_0000);
        chk("t2 rsp_ready r0",    32'(bus.icb_rsp_ready), 1);
        tick();
        bus.icb_rsp_rdata = 32'hB000_0001; m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t2 stall rsp_ready", 32'(bus.icb_rsp_ready), 0);
            chk("t2 stall m_valid",   32'(m_valid), 1);
            chk("t2 stall m_data",    m_data, 32'hB000_0001);
            chk("t2 stall busy",      32'(busy), 1);
            tick();
        end
        m_ready = 1'b1;
        settle();
        chk("t2 rsp_ready r1", 32'(bus.icb_rsp_ready), 1);
        chk("t2 m_data r1",    m_data, 32'hB000_0001);
        tick();
        bus.icb_rsp_rdata = 32'hB000_0002;
        settle();
        chk("t2 m_data r2",    m_data, 32'hB000_0002);
        chk("t2 done early",   32'(done), 0);
        tick();
        idle_inputs();
        settle();
        chk("t2 done", 32'(done), 1);
        tick();

        // ---------------- T3: outstanding limit, len=8 ----------------
        cfg_start = 1'b1; cfg_read = 1'b0; cfg_base = 32'h3000_0000; cfg_len = 16'd8;
        tick();
        cfg_start = 1'b0;
        s_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 32'hC000_0000 + 32'(i);
            settle();
            chk("t3 cmd_valid", 32'(bus.icb_cmd_valid), 1);
            chk("t3 addr",      bus.icb_cmd_addr, 32'h3000_0000 + 32'(4 * i));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t3 full cmd_valid", 32'(bus.icb_cmd_valid), 0);
            chk("t3 full s_ready",   32'(s_ready), 0);
            tick();
        end
        bus.icb_rsp_valid = 1'b1;
        settle();
        chk("t3 first rsp cmd_valid", 32'(bus.icb_cmd_valid), 0);
        tick();
        for (int i = 4; i < 8; i++) begin
            s_data = 32'hC000_0000 + 32'(i);
            settle();
            chk("t3 cmd_valid2", 32'(bus.icb_cmd_valid), 1);
            chk("t3 addr2",      bus.icb_cmd_addr, 32'h3000_0000 + 32'(4 * i));
            chk("t3 wdata2",     bus.icb_cmd_wdata, 32'hC000_0000 + 32'(i));
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3 drain cmd_valid", 32'(bus.icb_cmd_valid), 0);
            chk("t3 done early",      32'(done), 0);
            tick();
        end
        idle_inputs();
        settle();
        chk("t3 done", 32'(done), 1);
        tick();

        // ---------------- T4: address wrap + error response ----------------
        cfg_start = 1'b1; cfg_read = 1'b0; cfg_base = 32'hFFFF_FFF8; cfg_len = 16'd4;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid           = (i < 4);
            s_data            = 32'hD000_0000 + 32'(i);
            bus.icb_rsp_valid = (i >= 1);
            bus.icb_rsp_err   = (i == 2);
            a = 32'hFFFF_FFF8 + 32'(4 * i);
            settle();
            if (i < 4) chk("t4 addr", bus.icb_cmd_addr, a);
            if (i >= 3) chk("t4 err sticky", 32'(err), 1);
            else        chk("t4 err clear",  32'(err), 0);
            tick();
        end
        idle_inputs();
        settle();
        chk("t4 done",     32'(done), 1);
        chk("t4 err done", 32'(err), 1);
        tick();
        chk("t4 err held", 32'(err), 1);

        // ---------------- T5: len=0 start (also clears err) ----------------
        cfg_start = 1'b1; cfg_read = 1'b0; cfg_base = 32'h5000_0000; cfg_len = 16'd0;
        settle();
        chk("t5 cmd_valid start", 32'(bus.icb_cmd_valid), 0);
        tick();
        cfg_start = 1'b0;
        settle();
        chk("t5 done",      32'(done), 1);
        chk("t5 busy",      32'(busy), 0);
        chk("t5 err clear", 32'(err), 0);
        chk("t5 cmd_valid", 32'(bus.icb_cmd_valid), 0);
        tick();
        chk("t5 done once", 32'(done), 0);
        chk("t5 busy2",     32'(busy), 0);

        // ---------------- T6: start ignored mid-RUN, then reset ----------------
        cfg_start = 1'b1; cfg_read = 1'b0; cfg_base = 32'h4000_0000; cfg_len = 16'd8;
        tick();
        cfg_start = 1'b0;
        s_valid   = 1'b1;
        settle();
        chk("t6 addr0", bus.icb_cmd_addr, 32'h4000_0000);
        tick();
        cfg_start = 1'b1; cfg_read = 1'b1; cfg_base = 32'h5000_0000; cfg_len = 16'd2;
        settle();
        chk("t6 addr1",     bus.icb_cmd_addr, 32'h4000_0004);
        chk("t6 cmd_read1", 32'(bus.icb_cmd_read), 0);
        tick();
        cfg_start = 1'b0;
        settle();
        chk("t6 addr2",     bus.icb_cmd_addr, 32'h4000_0008);
        chk("t6 cmd_read2", 32'(bus.icb_cmd_read), 0);
        chk("t6 busy",      32'(busy), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.icb_rsp_valid = 1'b1; bus.icb_rsp_rdata = 32'hEEEE_0000;
        settle();
        chk("t6 rst busy",      32'(busy), 0);
        chk("t6 rst done",      32'(done), 0);
        chk("t6 rst err",       32'(err), 0);
        chk("t6 rst cmd_valid", 32'(bus.icb_cmd_valid), 0);
        chk("t6 rst s_ready",   32'(s_ready), 0);
        chk("t6 stale m_valid", 32'(m_valid), 0);
        chk("t6 stale rsp_rdy", 32'(bus.icb_rsp_ready), 1);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6 no done", 32'(done), 0);
            chk("t6 idle busy", 32'(busy), 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
